// File: rtl/dz_rx_silo.sv
// DZ11 receive silo: scans eight UART receivers and queues line-tagged
// characters in a FIFO whose head is presented as the RBUF image.
module dz_rx_silo #(
  parameter int DEPTH = 64,
  parameter int ALARM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        csrMSE,
  input  logic        csrSAE,
  input  logic [7:0]  uartRXFULL,
  input  logic [63:0] uartRXDATA,
  output logic [7:0]  uartRXCLR,
  input  logic        rbufREAD,
  output logic [15:0] rbufDATA,
  output logic        csrRDONE,
  output logic        csrSA,
  output logic        rxRRDY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] ALARM_CNT = CW'(ALARM);

  logic [2:0]    scanIdx;
  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [11:0]   mem [DEPTH];
  logic          ovrSticky;
  logic          saReg;
  logic          rbufReadD;
  logic [7:0]    clrPulse_p1;

  logic          initNow;
  logic          full;
  logic          empty;
  logic          sample;
  logic [7:0]    sampleData;
  logic          readEdge;
  logic          doPop;
  logic          doPush;
  logic          setOvr;
  logic [11:0]   pushEntry;
  logic [11:0]   headEntry;

  assign initNow    = rst | clr;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign sample     = csrMSE & uartRXFULL[scanIdx];
  assign sampleData = uartRXDATA[{scanIdx, 3'b000} +: 8];
  assign readEdge   = rbufREAD & ~rbufReadD;
  assign doPop      = readEdge & ~empty;
  // A pop in the same cycle frees the slot, so a full silo still accepts.
  assign doPush     = sample & (~full | doPop);
  assign setOvr     = sample & full & ~doPop;
  assign pushEntry  = {ovrSticky, scanIdx, sampleData};

  always_comb begin
    countNext = count;
    case ({doPush, doPop})
      2'b10:   countNext = count + CW'(1);
      2'b01:   countNext = count - CW'(1);
      default: countNext = count;
    endcase
  end

  // ---- p0 -> p1: scanner, pointers, flags and acknowledge pulse ----
  always_ff @(posedge clk) begin
    if (initNow) begin
      scanIdx     <= '0;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      ovrSticky   <= 1'b0;
      saReg       <= 1'b0;
      rbufReadD   <= 1'b0;
      clrPulse_p1 <= '0;
    end else begin
      if (csrMSE)
        scanIdx <= scanIdx + 3'd1;
      clrPulse_p1 <= sample ? (8'd1 << scanIdx) : 8'd0;
      rbufReadD   <= rbufREAD;
      count       <= countNext;
      if (doPop)
        rdPtr <= rdPtr + PW'(1);
      if (doPush)
        wrPtr <= wrPtr + PW'(1);
      if (doPush)
        ovrSticky <= 1'b0;
      else if (setOvr)
        ovrSticky <= 1'b1;
      // Alarm only arms on a push; any pop edge drops it until the next push.
      if (!csrSAE || doPop)
        saReg <= 1'b0;
      else if (doPush && (countNext >= ALARM_CNT))
        saReg <= 1'b1;
    end
  end

  // ---- p0 -> p1: silo storage (data only, never reset) ----
  always_ff @(posedge clk) begin
    if (doPush && !initNow)
      mem[wrPtr] <= pushEntry;
  end

  assign headEntry = mem[rdPtr];
  assign rbufDATA  = empty ? 16'h0000
                           : {1'b1, headEntry[11], 3'b000, headEntry[10:0]};
  assign uartRXCLR = clrPulse_p1;
  assign csrRDONE  = ~empty;
  assign csrSA     = saReg & csrSAE;
  assign rxRRDY    = csrSAE ? csrSA : csrRDONE;

endmodule

// File: tb/tb_dz_rx_silo.sv
// Bench for dz_rx_silo: directed steps plus random traffic, every cycle
// compared against a queue-based model of the silo.
module tb_dz_rx_silo;

  localparam int DEPTH = 64;
  localparam int ALARM = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        csrMSE;
  logic        csrSAE;
  logic [7:0]  uartRXFULL;
  logic [63:0] uartRXDATA;
  logic [7:0]  uartRXCLR;
  logic        rbufREAD;
  logic [15:0] rbufDATA;
  logic        csrRDONE;
  logic        csrSA;
  logic        rxRRDY;

  dz_rx_silo #(.DEPTH(DEPTH), .ALARM(ALARM)) dut (
    .clk(clk), .rst(rst), .clr(clr), .csrMSE(csrMSE), .csrSAE(csrSAE),
    .uartRXFULL(uartRXFULL), .uartRXDATA(uartRXDATA), .uartRXCLR(uartRXCLR),
    .rbufREAD(rbufREAD), .rbufDATA(rbufDATA), .csrRDONE(csrRDONE),
    .csrSA(csrSA), .rxRRDY(rxRRDY)
  );

  always #5 clk = ~clk;

  logic [15:0] q[$];
  logic        mOvr;
  logic        mSa;
  logic        mPrevRd;
  int          mIdx;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setLine(input int n, input logic [7:0] d);
    uartRXFULL[n] = 1'b1;
    uartRXDATA[n*8 +: 8] = d;
  endtask

  // Predict the effect of the coming clock edge, then compare after it.
  task automatic cycle();
    logic [7:0]  expClr;
    logic [15:0] expRbuf;
    logic        svc;
    logic        doPop;
    logic        pushed;
    logic        expSa;
    int          ln;
    expClr = '0;
    svc    = 1'b0;
    pushed = 1'b0;
    ln     = 0;
    if (rst || clr) begin
      q.delete();
      mOvr = 1'b0; mSa = 1'b0; mPrevRd = 1'b0; mIdx = 0;
    end else begin
      ln    = mIdx;
      svc   = csrMSE && uartRXFULL[ln];
      doPop = rbufREAD && !mPrevRd && (q.size() > 0);
      if (doPop) void'(q.pop_front());
      if (svc) begin
        expClr[ln] = 1'b1;
        if (q.size() < DEPTH) begin
          q.push_back({1'b1, mOvr, 3'b000, 3'(ln), uartRXDATA[ln*8 +: 8]});
          pushed = 1'b1;
          mOvr = 1'b0;
        end else begin
          mOvr = 1'b1;
        end
      end
      if (!csrSAE || doPop) mSa = 1'b0;
      else if (pushed && q.size() >= ALARM) mSa = 1'b1;
      mPrevRd = rbufREAD;
      if (csrMSE) mIdx = (mIdx + 1) % 8;
    end
    @(posedge clk);
    #1;
    if (svc) uartRXFULL[ln] = 1'b0;
    expRbuf = (q.size() > 0) ? q[0] : 16'h0000;
    expSa   = mSa && csrSAE;
    chk("rbufDATA", rbufDATA, expRbuf);
    chk("csrRDONE", {15'd0, csrRDONE}, {15'd0, q.size() > 0});
    chk("csrSA", {15'd0, csrSA}, {15'd0, expSa});
    chk("rxRRDY", {15'd0, rxRRDY}, {15'd0, csrSAE ? expSa : (q.size() > 0)});
    chk("uartRXCLR", {8'd0, uartRXCLR}, {8'd0, expClr});
  endtask

  task automatic fillTo(input int target);
    for (int i = 0; i < 300 && q.size() < target; i++) begin
      setLine(mIdx, 8'($urandom_range(0, 255)));
      cycle();
    end
  endtask

  task automatic drainTo(input int target);
    for (int i = 0; i < 300 && q.size() > target; i++) begin
      rbufREAD = 1'b1; cycle();
      rbufREAD = 1'b0; cycle();
    end
  endtask

  task automatic waitLine(input int n);
    for (int i = 0; i < 20 && uartRXFULL[n]; i++) cycle();
  endtask

  initial begin
    logic [7:0] d6;
    int ln;
    rst = 1'b1; clr = 1'b0; csrMSE = 1'b0; csrSAE = 1'b0; rbufREAD = 1'b0;
    uartRXFULL = '0; uartRXDATA = '0;
    mOvr = 1'b0; mSa = 1'b0; mPrevRd = 1'b0; mIdx = 0;

    // Reset state
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_rbuf", rbufDATA, 16'h0000);
    chk("rst_rdone", {15'd0, csrRDONE}, 16'd0);
    chk("rst_rrdy", {15'd0, rxRRDY}, 16'd0);
    chk("rst_clr", {8'd0, uartRXCLR}, 16'd0);

    // Line 3 delivers 0x41
    csrMSE = 1'b1;
    setLine(3, 8'h41);
    waitLine(3);
    chk("l3_rbuf", rbufDATA, 16'h8341);
    chk("l3_clr", {8'd0, uartRXCLR}, 16'h0008);
    chk("l3_rdone", {15'd0, csrRDONE}, 16'd1);
    chk("l3_rrdy", {15'd0, rxRRDY}, 16'd1);
    cycle();
    chk("l3_clr_once", {8'd0, uartRXCLR}, 16'h0000);

    // Held strobe pops once
    d6 = 8'($urandom_range(0, 255));
    setLine(6, d6);
    waitLine(6);
    rbufREAD = 1'b1;
    repeat (5) cycle();
    rbufREAD = 1'b0;
    cycle();
    chk("held_second", rbufDATA, {8'h86, d6});
    rbufREAD = 1'b1; cycle();
    rbufREAD = 1'b0; cycle();
    chk("held_empty", rbufDATA, 16'h0000);

    // Silo alarm threshold
    csrSAE = 1'b1;
    fillTo(ALARM - 1);
    chk("sa15_rrdy", {15'd0, rxRRDY}, 16'd0);
    fillTo(ALARM);
    chk("sa16_sa", {15'd0, csrSA}, 16'd1);
    chk("sa16_rrdy", {15'd0, rxRRDY}, 16'd1);
    rbufREAD = 1'b1; cycle();
    chk("sa_pop_clr", {15'd0, csrSA}, 16'd0);
    rbufREAD = 1'b0; cycle();

    // Overrun on a full silo
    csrSAE = 1'b0;
    fillTo(DEPTH);
    setLine(5, 8'h7E);
    waitLine(5);
    chk("ovr_clr5", {8'd0, uartRXCLR}, 16'h0020);
    chk("ovr_rdone", {15'd0, csrRDONE}, 16'd1);
    rbufREAD = 1'b1; cycle();
    rbufREAD = 1'b0; cycle();
    setLine(2, 8'h30);
    waitLine(2);
    rbufREAD = 1'b1; cycle();
    rbufREAD = 1'b0; cycle();
    setLine(6, 8'h55);
    waitLine(6);
    drainTo(2);
    chk("ovr_flag", rbufDATA, 16'hC230);
    drainTo(1);
    chk("ovr_next", rbufDATA, 16'h8655);

    // Full silo: pop edge together with a push
    fillTo(DEPTH);
    setLine(mIdx, 8'($urandom_range(0, 255)));
    rbufREAD = 1'b1; cycle();
    rbufREAD = 1'b0; cycle();
    rbufREAD = 1'b1; cycle();
    rbufREAD = 1'b0; cycle();
    fillTo(DEPTH);
    drainTo(1);
    chk("full_pp_noovr", {15'd0, rbufDATA[14]}, 16'd0);
    drainTo(0);

    // Empty silo: push with read edge
    ln = mIdx;
    setLine(ln, 8'h3C);
    rbufREAD = 1'b1; cycle();
    rbufREAD = 1'b0;
    chk("empty_pp_rdone", {15'd0, csrRDONE}, 16'd1);
    chk("empty_pp_rbuf", rbufDATA, {5'b10000, 3'(ln), 8'h3C});
    cycle();
    drainTo(0);

    // clr with alarm and overrun pending
    csrSAE = 1'b1;
    fillTo(DEPTH);
    setLine(mIdx, 8'($urandom_range(0, 255)));
    cycle();
    setLine(mIdx, 8'($urandom_range(0, 255)));
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr_rbuf", rbufDATA, 16'h0000);
    chk("clr_sa", {15'd0, csrSA}, 16'd0);
    chk("clr_uclr", {8'd0, uartRXCLR}, 16'd0);
    chk("clr_rrdy", {15'd0, rxRRDY}, 16'd0);
    repeat (8) cycle();
    chk("clr_ovr_gone", {14'd0, rbufDATA[15:14]}, 16'h0002);
    drainTo(0);

    // Scanning disabled
    csrMSE = 1'b0;
    for (int n = 0; n < 8; n++) setLine(n, 8'($urandom_range(0, 255)));
    repeat (16) cycle();
    chk("mse0_uclr", {8'd0, uartRXCLR}, 16'd0);
    chk("mse0_rdone", {15'd0, csrRDONE}, 16'd0);

    // Random traffic
    for (int t = 0; t < 600; t++) begin
      csrMSE = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) csrSAE = ~csrSAE;
      rbufREAD = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 299) == 0);
      for (int n = 0; n < 8; n++)
        if (!uartRXFULL[n] && $urandom_range(0, 3) == 0)
          setLine(n, 8'($urandom_range(0, 255)));
      cycle();
      clr = 1'b0;
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
